// File: rtl/axi_slave_regfile.sv
// axi_slave_regfile: AXI-lite style slave with a 16 x 32-bit register file and
// burst reads. Registers 0-14 are read/write; register 15 always reads ID_VALUE
// and ignores writes. Register 0 is also driven out live on O_CTRL.
//
// Ports
//   S_ACLK, S_ARESET                  clock, synchronous active-high reset
//   M_AWVALID/M_AWADDR, S_AWREADY     write address
//   M_WVALID/M_WDATA/M_WSTRB, S_WREADY write data with byte strobes
//   S_BVALID/S_BRESP, M_BREADY        write response
//   M_ARVALID/M_ARADDR/M_BLEN, S_ARREADY read address, M_BLEN+1 beats
//   S_RVALID/S_RDATA/S_RRESP/S_RLAST, M_RREADY read data
//   O_CTRL                            live copy of register 0
//
// state  | meaning
// W_IDLE | collecting AW and W in any order
// W_RESP | write done, holding B until M_BREADY
// R_IDLE | ready for a new read address
// R_DATA | presenting read beats until the last is taken
module axi_slave_regfile #(
  parameter logic [31:0] ID_VALUE = 32'hA5A5_0001
) (
  input  logic        S_ACLK,
  input  logic        S_ARESET,
  input  logic        M_AWVALID,
  input  logic [31:0] M_AWADDR,
  output logic        S_AWREADY,
  input  logic        M_WVALID,
  input  logic [31:0] M_WDATA,
  input  logic [3:0]  M_WSTRB,
  output logic        S_WREADY,
  output logic        S_BVALID,
  output logic [1:0]  S_BRESP,
  input  logic        M_BREADY,
  input  logic        M_ARVALID,
  input  logic [31:0] M_ARADDR,
  input  logic [3:0]  M_BLEN,
  output logic        S_ARREADY,
  output logic        S_RVALID,
  output logic [31:0] S_RDATA,
  output logic [1:0]  S_RRESP,
  output logic        S_RLAST,
  input  logic        M_RREADY,
  output logic [31:0] O_CTRL
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  logic [31:0] regs [16];

  w_state_t    w_state;
  logic        aw_done, w_done, aw_ok;
  logic [3:0]  aw_idx;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  r_state_t    r_state;
  logic        r_ok;
  logic [3:0]  r_idx, beats_left;
  logic        rvalid_q, rlast_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        aw_fire, w_fire, have_aw, have_w, commit, wr_en;
  logic [3:0]  tgt_idx;
  logic        tgt_ok, ar_ok;
  logic [31:0] tgt_data;
  logic [3:0]  tgt_strb;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{M_AWADDR[1:0], M_ARADDR[1:0]};

  // Outputs are forced low combinationally while reset is held, so they read
  // zero even in the cycle reset first rises.
  assign S_AWREADY = ~S_ARESET & (w_state == W_IDLE) & ~aw_done;
  assign S_WREADY  = ~S_ARESET & (w_state == W_IDLE) & ~w_done;
  assign S_BVALID  = ~S_ARESET & bvalid_q;
  assign S_BRESP   = S_ARESET ? 2'b00 : bresp_q;
  assign S_ARREADY = ~S_ARESET & (r_state == R_IDLE);
  assign S_RVALID  = ~S_ARESET & rvalid_q;
  assign S_RDATA   = S_ARESET ? 32'd0 : rdata_q;
  assign S_RRESP   = S_ARESET ? 2'b00 : rresp_q;
  assign S_RLAST   = ~S_ARESET & rlast_q;
  assign O_CTRL    = regs[0];

  // Merge the freshly accepted channel with whatever was captured earlier so
  // the commit can happen on the same edge as the later of AW/W.
  always_comb begin
    aw_fire  = S_AWREADY & M_AWVALID;
    w_fire   = S_WREADY & M_WVALID;
    have_aw  = aw_done | aw_fire;
    have_w   = w_done | w_fire;
    tgt_idx  = aw_fire ? M_AWADDR[5:2] : aw_idx;
    tgt_ok   = aw_fire ? (M_AWADDR[31:6] == 26'd0) : aw_ok;
    tgt_data = w_fire ? M_WDATA : wdata_q;
    tgt_strb = w_fire ? M_WSTRB : wstrb_q;
    commit   = (w_state == W_IDLE) & have_aw & have_w;
    wr_en    = commit & tgt_ok & (tgt_idx != 4'd15);
    ar_ok    = (M_ARADDR[31:6] == 26'd0);
  end

  function automatic logic [31:0] rd_word(input logic [3:0] idx);
    return (idx == 4'd15) ? ID_VALUE : regs[idx];
  endfunction

  always_ff @(posedge S_ACLK) begin
    if (S_ARESET) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (tgt_strb[b]) regs[tgt_idx][8*b +: 8] <= tgt_data[8*b +: 8];
    end
  end

  always_ff @(posedge S_ACLK) begin
    if (S_ARESET) begin
      w_state  <= W_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_idx   <= 4'd0;
      aw_ok    <= 1'b0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= tgt_ok ? RESP_OKAY : RESP_SLVERR;
            w_state  <= W_RESP;
          end else begin
            if (aw_fire) begin
              aw_done <= 1'b1;
              aw_idx  <= M_AWADDR[5:2];
              aw_ok   <= (M_AWADDR[31:6] == 26'd0);
            end
            if (w_fire) begin
              w_done  <= 1'b1;
              wdata_q <= M_WDATA;
              wstrb_q <= M_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (M_BREADY) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // beats_left counts down to zero; the beat presented while it is zero is
  // the last one.
  always_ff @(posedge S_ACLK) begin
    if (S_ARESET) begin
      r_state    <= R_IDLE;
      r_ok       <= 1'b0;
      r_idx      <= 4'd0;
      beats_left <= 4'd0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= 32'd0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (M_ARVALID) begin
            r_idx      <= M_ARADDR[5:2];
            r_ok       <= ar_ok;
            beats_left <= M_BLEN;
            rdata_q    <= ar_ok ? rd_word(M_ARADDR[5:2]) : 32'd0;
            rresp_q    <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_q    <= (M_BLEN == 4'd0);
            rvalid_q   <= 1'b1;
            r_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (M_RREADY) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              rdata_q  <= 32'd0;
              rresp_q  <= RESP_OKAY;
              r_state  <= R_IDLE;
            end else begin
              r_idx      <= r_idx + 4'd1;
              beats_left <= beats_left - 4'd1;
              rdata_q    <= r_ok ? rd_word(r_idx + 4'd1) : 32'd0;
              rlast_q    <= (beats_left == 4'd1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_regfile.sv
// Directed bench for axi_slave_regfile: a transaction-level model checked every
// cycle on the falling edge, plus literal expectations per scenario.
module tb_axi_slave_regfile;
  localparam logic [31:0] ID = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M_AWVALID = 0, M_WVALID = 0, M_BREADY = 0, M_ARVALID = 0, M_RREADY = 0;
  logic [31:0] M_AWADDR = 0, M_WDATA = 0, M_ARADDR = 0;
  logic [3:0]  M_WSTRB = 0, M_BLEN = 0;
  logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, S_RLAST;
  logic [1:0]  S_BRESP, S_RRESP;
  logic [31:0] S_RDATA, O_CTRL;

  axi_slave_regfile #(.ID_VALUE(ID)) dut (
    .S_ACLK(clk), .S_ARESET(rst),
    .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .S_AWREADY(S_AWREADY),
    .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .M_BREADY(M_BREADY),
    .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .M_BLEN(M_BLEN), .S_ARREADY(S_ARREADY),
    .S_RVALID(S_RVALID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .M_RREADY(M_RREADY), .O_CTRL(O_CTRL)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] mreg [16];
  bit          aw_pend, w_pend, b_pend, r_act, r_ok;
  logic [31:0] m_awaddr, m_wdata, r_data;
  logic [3:0]  m_wstrb, r_idx, r_left, m_idx;
  logic [1:0]  m_bresp;

  function automatic logic [31:0] mread(input logic [3:0] i);
    return (i == 4'd15) ? ID : mreg[i];
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_awready", S_AWREADY, 0);
      check("rst_wready", S_WREADY, 0);
      check("rst_bvalid", S_BVALID, 0);
      check("rst_bresp", S_BRESP, 0);
      check("rst_arready", S_ARREADY, 0);
      check("rst_rvalid", S_RVALID, 0);
      check("rst_rdata", S_RDATA, 0);
      check("rst_rresp", S_RRESP, 0);
      check("rst_rlast", S_RLAST, 0);
      for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
      aw_pend = 0; w_pend = 0; b_pend = 0; r_act = 0;
    end else begin
      check("awready", S_AWREADY, !(b_pend || aw_pend));
      check("wready", S_WREADY, !(b_pend || w_pend));
      check("bvalid", S_BVALID, b_pend);
      if (b_pend) check("bresp", S_BRESP, m_bresp);
      check("arready", S_ARREADY, !r_act);
      check("rvalid", S_RVALID, r_act);
      if (r_act) begin
        check("rdata", S_RDATA, r_data);
        check("rresp", S_RRESP, r_ok ? 2'b00 : 2'b10);
        check("rlast", S_RLAST, r_left == 4'd0);
      end
      check("o_ctrl", O_CTRL, mreg[0]);
      // read side first: loads at this edge see pre-write contents
      if (r_act) begin
        if (M_RREADY) begin
          if (r_left == 4'd0) r_act = 0;
          else begin
            r_left = r_left - 4'd1;
            r_idx  = r_idx + 4'd1;
            r_data = r_ok ? mread(r_idx) : 32'd0;
          end
        end
      end else if (M_ARVALID) begin
        r_act  = 1;
        r_idx  = M_ARADDR[5:2];
        r_ok   = (M_ARADDR[31:6] == 0);
        r_left = M_BLEN;
        r_data = r_ok ? mread(r_idx) : 32'd0;
      end
      if (b_pend) begin
        if (M_BREADY) b_pend = 0;
      end else begin
        if (M_AWVALID && !aw_pend) begin aw_pend = 1; m_awaddr = M_AWADDR; end
        if (M_WVALID && !w_pend) begin w_pend = 1; m_wdata = M_WDATA; m_wstrb = M_WSTRB; end
        if (aw_pend && w_pend) begin
          m_idx = m_awaddr[5:2];
          if (m_awaddr[31:6] == 0 && m_idx != 4'd15)
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) mreg[m_idx][8*b +: 8] = m_wdata[8*b +: 8];
          m_bresp = (m_awaddr[31:6] == 0) ? 2'b00 : 2'b10;
          b_pend  = 1;
          aw_pend = 0;
          w_pend  = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] bd[$];
  logic [1:0]  br[$];
  logic        bl[$];

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, output logic [1:0] resp);
    bit aw_ok = 0, w_ok = 0, bdone = 0;
    resp = 2'bxx;
    for (int t = 0; t < 40 && !bdone; t++) begin
      M_AWADDR  = addr;
      M_AWVALID = !aw_ok && (t >= aw_dly);
      M_WDATA   = data;
      M_WSTRB   = strb;
      M_WVALID  = !w_ok;
      M_BREADY  = aw_ok && w_ok;
      @(negedge clk);
      if (M_AWVALID && S_AWREADY) aw_ok = 1;
      if (M_WVALID && S_WREADY) w_ok = 1;
      if (M_BREADY && S_BVALID) begin resp = S_BRESP; bdone = 1; end
      @(posedge clk); #1;
    end
    M_AWVALID = 0; M_WVALID = 0; M_BREADY = 0;
    checks++;
    if (!bdone) begin errors++; $display("FAIL write_timeout: addr %h got no response, expected one", addr); end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] blen, input bit toggle);
    bit ar_acc = 0, done = 0;
    bd.delete(); br.delete(); bl.delete();
    M_ARADDR = addr;
    M_BLEN   = blen;
    for (int k = 0; k < 60 && !done; k++) begin
      M_ARVALID = !ar_acc;
      M_RREADY  = ar_acc && (toggle ? k[0] : 1'b1);
      @(negedge clk);
      if (M_ARVALID && S_ARREADY) ar_acc = 1;
      else if (M_RREADY && S_RVALID) begin
        bd.push_back(S_RDATA); br.push_back(S_RRESP); bl.push_back(S_RLAST);
        if (S_RLAST) done = 1;
      end
      @(posedge clk); #1;
    end
    M_ARVALID = 0; M_RREADY = 0;
    checks++;
    if (!done) begin errors++; $display("FAIL read_timeout: addr %h got %0d beats, expected %0d", addr, bd.size(), blen + 1); end
  endtask

  logic [1:0] resp;
  int         seen;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("post_rst_awready", S_AWREADY, 1);
    check("post_rst_arready", S_ARREADY, 1);
    check("post_rst_octrl", O_CTRL, 0);
    @(posedge clk); #1;

    // same-cycle AW/W, then single-beat read back
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, resp);
    check("t1_bresp", resp, 2'b00);
    do_read(32'h04, 4'd0, 0);
    check("t1_nbeats", bd.size(), 1);
    if (bd.size() == 1) begin
      check("t1_rdata", bd[0], 32'hDEADBEEF);
      check("t1_rlast", bl[0], 1);
      check("t1_rresp", br[0], 2'b00);
    end

    // W two cycles ahead of AW, partial strobes over all-ones
    do_write(32'h00, 32'hFFFFFFFF, 4'hF, 0, resp);
    do_write(32'h00, 32'h11223344, 4'b0101, 2, resp);
    check("t2_bresp", resp, 2'b00);
    check("t2_octrl", O_CTRL, 32'hFF22FF44);

    // wrapping burst from reg14 with RREADY toggling
    do_write(32'h38, 32'hCAFE0014, 4'hF, 0, resp);
    do_read(32'h38, 4'd3, 1);
    check("t3_nbeats", bd.size(), 4);
    if (bd.size() == 4) begin
      check("t3_b0", bd[0], 32'hCAFE0014);
      check("t3_b1", bd[1], ID);
      check("t3_b2", bd[2], 32'hFF22FF44);
      check("t3_b3", bd[3], 32'hDEADBEEF);
      check("t3_last", {bl[0], bl[1], bl[2], bl[3]}, 4'b0001);
    end

    // out-of-range write and read
    do_write(32'h40, 32'h12345678, 4'hF, 0, resp);
    check("t4_bresp", resp, 2'b10);
    check("t4_octrl", O_CTRL, 32'hFF22FF44);
    do_read(32'h100, 4'd1, 0);
    check("t4_nbeats", bd.size(), 2);
    if (bd.size() == 2) begin
      check("t4_d0", bd[0], 0);
      check("t4_d1", bd[1], 0);
      check("t4_r0", br[0], 2'b10);
      check("t4_r1", br[1], 2'b10);
      check("t4_last", {bl[0], bl[1]}, 2'b01);
    end

    // read-only ID register
    do_write(32'h3C, 32'hFFFFFFFF, 4'hF, 0, resp);
    check("t5_bresp", resp, 2'b00);
    do_read(32'h3C, 4'd0, 0);
    if (bd.size() == 1) check("t5_id", bd[0], ID);

    // simultaneous write and read load of reg2 returns the old value
    do_write(32'h08, 32'h0000AAAA, 4'hF, 0, resp);
    fork
      do_write(32'h08, 32'h0000BBBB, 4'hF, 0, resp);
      do_read(32'h08, 4'd0, 0);
    join
    if (bd.size() == 1) check("t6_old", bd[0], 32'h0000AAAA);
    do_read(32'h08, 4'd0, 0);
    if (bd.size() == 1) check("t6_new", bd[0], 32'h0000BBBB);

    // reset during beat 2 of 4 with a B response pending
    M_ARADDR = 32'h00; M_BLEN = 4'd3; M_ARVALID = 1;
    M_AWADDR = 32'h0C; M_AWVALID = 1; M_WDATA = 32'h55; M_WSTRB = 4'hF; M_WVALID = 1;
    M_BREADY = 0; M_RREADY = 0;
    @(posedge clk); #1;
    M_ARVALID = 0; M_AWVALID = 0; M_WVALID = 0; M_RREADY = 1;
    @(posedge clk); #1;
    M_RREADY = 0; rst = 1;
    @(negedge clk);
    check("t7_rvalid", S_RVALID, 0);
    check("t7_bvalid", S_BVALID, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 0;
    M_RREADY = 1; M_BREADY = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (S_RVALID || S_BVALID) seen++;
      @(posedge clk); #1;
    end
    check("t7_no_beats", seen, 0);
    M_RREADY = 0; M_BREADY = 0;
    check("t7_octrl", O_CTRL, 0);
    do_read(32'h00, 4'd14, 0);
    check("t7_nbeats", bd.size(), 15);
    for (int i = 0; i < bd.size(); i++) check($sformatf("t7_reg%0d", i), bd[i], 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave_regfile.md
AXI_SLAVE_REGFILE -- requirements
Module: axi_slave_regfile

Interface
REQ-001 Parameter: ID_VALUE, 32'hA5A5_0001, read-only content of register 15.
REQ-002 S_ACLK  in  1  single clock; all state updates on rising edge.
REQ-003 S_ARESET  in  1  one clock; reset is synchronous and active-high.
REQ-004 M_AWVALID  in  1, M_AWADDR  in  32, S_AWREADY  out  1  write-address channel.
REQ-005 M_WVALID  in  1, M_WDATA  in  32, M_WSTRB  in  4, S_WREADY  out  1  write-data channel.
REQ-006 S_BVALID  out  1, S_BRESP  out  2, M_BREADY  in  1  write-response channel.
REQ-007 M_ARVALID  in  1, M_ARADDR  in  32, M_BLEN  in  4, S_ARREADY  out  1  read-address channel; beats = M_BLEN+1.
REQ-008 S_RVALID  out  1, S_RDATA  out  32, S_RRESP  out  2, S_RLAST  out  1, M_RREADY  in  1  read-data channel.
REQ-009 O_CTRL  out  32  live copy of register 0.

Function
REQ-010 Storage: 16 x 32-bit registers; index = ADDR[5:2]; ADDR[1:0] ignored.
REQ-011 Address in range iff ADDR[31:6]==0; otherwise no storage access and response SLVERR (2'b10); in range gives OKAY (2'b00).
REQ-012 Register 15 is read-only (reads ID_VALUE); writes to it are dropped with OKAY.
REQ-013 Write FSM states: W_IDLE, W_RESP.
REQ-014 W_IDLE: S_AWREADY=1 until AW captured; S_WREADY=1 until W captured; AW and W accepted independently, any order or same cycle.
REQ-015 At the edge where the later of AW/W is accepted: byte lane i of target register written iff M_WSTRB[i]=1; FSM moves to W_RESP.
REQ-016 Latency: AW and W both valid in cycle N -> register updated at end of N, S_BVALID=1 in N+1.
REQ-017 W_RESP: S_AWREADY=S_WREADY=0; S_BVALID=1 and S_BRESP held stable until M_BREADY=1; then W_IDLE next cycle with capture flags cleared.
REQ-018 Read FSM states: R_IDLE, R_DATA.
REQ-019 R_IDLE: S_ARREADY=1; on M_ARVALID latch index, M_BLEN, range status; load S_RDATA; go R_DATA; S_RVALID=1 next cycle.
REQ-020 R_DATA: S_ARREADY=0; S_RVALID=1; S_RDATA/S_RRESP/S_RLAST stable until M_RREADY=1.
REQ-021 Each beat handshake: beat counter +1, index +1 modulo 16 (15 wraps to 0), S_RDATA reloaded; on last beat (counter==latched M_BLEN, S_RLAST=1) return to R_IDLE, S_RVALID=0 next cycle.
REQ-022 Out-of-range read: every beat S_RDATA=0, S_RRESP=2'b10; beat count still M_BLEN+1.
REQ-023 S_RDATA is registered; a write and a read load of the same register at the same edge return the pre-write value.
REQ-024 Read and write FSMs operate concurrently with no mutual stall.
REQ-025 M_BLEN=0 -> single beat with S_RLAST=1 on it.

Reset
REQ-026 While S_ARESET=1: all ready/valid outputs 0, S_BRESP=S_RRESP=0, S_RDATA=0, S_RLAST=0.
REQ-027 Reset clears registers 0-14 to 0, O_CTRL=0, both FSMs to idle, capture flags and beat counter to 0.
REQ-028 Reset mid-transaction aborts it; no pending B or R beat is emitted afterwards; in-flight write not yet committed is lost.
REQ-029 First cycle after S_ARESET deasserts: S_AWREADY=S_WREADY=S_ARREADY=1.

Verification
REQ-030 AW=0x04 and W=0xDEADBEEF, STRB=4'hF same cycle -> S_BVALID next cycle, BRESP=00; read 0x04 -> 0xDEADBEEF, RLAST=1.
REQ-031 W (0x11223344, STRB=4'b0101) two cycles before AW=0x00 over 0xFFFFFFFF -> reg0=O_CTRL=0xFF22FF44; BVALID only after AW accepted.
REQ-032 AR=0x38, M_BLEN=3, M_RREADY toggled 1/0 -> beats reg14, ID_VALUE, reg0, reg1; RLAST only on 4th; data stable during RREADY=0.
REQ-033 Write 0x40 and read 0x100, M_BLEN=1 -> BRESP=10, no register changed; two beats RDATA=0, RRESP=10.
REQ-034 Write to 0x3C -> BRESP=00, read 0x3C still ID_VALUE; simultaneous write reg2 and read reg2 load -> old value returned.
REQ-035 Assert S_ARESET during R_DATA beat 2 of 4 and while BVALID pending -> outputs 0, no further beats or B, regs 0-14 read 0.
